// File: rtl/isr_ctrl_if.sv
// Signal bundle between isr_ctrl and its surroundings (CPU INTA, resolver, command writes).
// master = environment driving requests; slave = isr_ctrl.
interface isr_ctrl_if;
  logic       inta_n;
  logic       intr_in;
  logic [7:0] isr_set;
  logic       aeoi;
  logic       icw2_wr;
  logic [4:0] icw2_data;
  logic       ocw2_wr;
  logic [7:0] ocw2_data;
  logic [7:0] isr;
  logic [7:0] eoi;
  logic [2:0] sp;
  logic       int_out;
  logic [7:0] vec;
  logic       vec_oe;

  modport master (
    output inta_n, intr_in, isr_set, aeoi, icw2_wr, icw2_data, ocw2_wr, ocw2_data,
    input  isr, eoi, sp, int_out, vec, vec_oe
  );

  modport slave (
    input  inta_n, intr_in, isr_set, aeoi, icw2_wr, icw2_data, ocw2_wr, ocw2_data,
    output isr, eoi, sp, int_out, vec, vec_oe
  );
endinterface

// File: rtl/isr_ctrl.sv
// 8259A in-service register, INTA sequencer and OCW2 EOI/rotate executor.
// Optional macro ROTATE_AEOI_EN enables rotate-on-automatic-EOI (OCW2 100/000).
module isr_ctrl #(
  parameter logic [2:0] SP_RESET    = 3'd7,
  parameter logic [4:0] VEC_T_RESET = 5'h08
) (
  input logic         clk,
  input logic         reset_n,
  isr_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StAck1, StWait2, StAck2} state_e;

  state_e     state_q;
  logic       inta_q;
  logic [7:0] isr_q, isr_d;
  logic [7:0] eoi_q, eoi_d;
  logic [2:0] sp_q, sp_d;
  logic [4:0] vt_q;
  logic [2:0] lvl_q;
  logic       spur_q;
  logic       int_out_q;
  logic [7:0] vec_q;
  logic       vec_oe_q;
  logic       rot_q, rot_d;

  logic       fall, rise;
  logic [2:0] hi_lvl;
  logic [2:0] ocw_l;
  logic [7:0] clr_ocw, clr_aeoi, set_mask;
  logic       aeoi_done;
  logic       unused_ocw;

  assign fall       = inta_q & ~bus.inta_n;
  assign rise       = ~inta_q & bus.inta_n;
  assign ocw_l      = bus.ocw2_data[2:0];
  assign unused_ocw = ^bus.ocw2_data[4:3];

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Highest in-service level: first set bit scanning upward from sp+1, wrapping.
  function automatic logic [2:0] highest(input logic [7:0] v, input logic [2:0] sp);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = sp + 3'(k);
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign hi_lvl = highest(isr_q, sp_q);

  always_comb begin
    clr_ocw   = 8'h00;
    sp_d      = sp_q;
    rot_d     = rot_q;
    aeoi_done = (state_q == StAck2) && rise && bus.aeoi && !spur_q;
    clr_aeoi  = aeoi_done ? ((8'h01 << lvl_q) & isr_q) : 8'h00;
`ifdef ROTATE_AEOI_EN
    if (aeoi_done && rot_q) sp_d = lvl_q;
`endif
    // OCW2 is evaluated after AEOI so an explicit priority command wins on sp.
    if (bus.ocw2_wr) begin
      case (bus.ocw2_data[7:5])
        3'b001: if (|isr_q) clr_ocw[hi_lvl] = 1'b1;
        3'b011: clr_ocw[ocw_l] = isr_q[ocw_l];
        3'b101: begin
          if (|isr_q) begin
            clr_ocw[hi_lvl] = 1'b1;
            sp_d            = hi_lvl;
          end
        end
        3'b111: begin
          if (isr_q[ocw_l]) begin
            clr_ocw[ocw_l] = 1'b1;
            sp_d           = ocw_l;
          end
        end
        3'b110: sp_d = ocw_l;
`ifdef ROTATE_AEOI_EN
        3'b100: rot_d = 1'b1;
        3'b000: rot_d = 1'b0;
`endif
        default: ;
      endcase
    end
    set_mask = (state_q == StIdle && fall) ? bus.isr_set : 8'h00;
    // Set wins over a clear of the same bit in the same cycle.
    isr_d    = (isr_q & ~(clr_ocw | clr_aeoi)) | set_mask;
    eoi_d    = clr_ocw | clr_aeoi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      inta_q    <= 1'b1;
      isr_q     <= 8'h00;
      eoi_q     <= 8'h00;
      sp_q      <= SP_RESET;
      vt_q      <= VEC_T_RESET;
      lvl_q     <= 3'd0;
      spur_q    <= 1'b0;
      int_out_q <= 1'b0;
      vec_q     <= 8'h00;
      vec_oe_q  <= 1'b0;
      rot_q     <= 1'b0;
    end else begin
      inta_q    <= bus.inta_n;
      isr_q     <= isr_d;
      eoi_q     <= eoi_d;
      sp_q      <= sp_d;
      rot_q     <= rot_d;
      int_out_q <= (state_q == StIdle) ? bus.intr_in : 1'b0;
      if (bus.icw2_wr) vt_q <= bus.icw2_data;
      case (state_q)
        StIdle: if (fall) begin
          state_q <= StAck1;
          lvl_q   <= encode(bus.isr_set);
          spur_q  <= (bus.isr_set == 8'h00);
        end
        StAck1: if (rise) state_q <= StWait2;
        StWait2: if (fall) begin
          state_q  <= StAck2;
          vec_q    <= {vt_q, lvl_q};
          vec_oe_q <= 1'b1;
        end
        StAck2: if (rise) begin
          state_q  <= StIdle;
          vec_oe_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.isr     = isr_q;
  assign bus.eoi     = eoi_q;
  assign bus.sp      = sp_q;
  assign bus.int_out = int_out_q;
  assign bus.vec     = vec_q;
  assign bus.vec_oe  = vec_oe_q;

endmodule

// File: tb/tb_isr_ctrl.sv
// Directed self-checking bench for isr_ctrl; expected values are hand-computed.
module tb_isr_ctrl;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] eoi_seen;

  isr_ctrl_if bus ();

  isr_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1();
    bus.inta_n = 1'b0;
    tick();
    tick();
    bus.inta_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic pulse2(input string tag, input logic [7:0] exp_vec, output logic [7:0] eoi_o);
    bus.inta_n = 1'b0;
    tick();
    check({tag, "_vec_oe_on"}, 32'(bus.vec_oe), 32'd1);
    check({tag, "_vec"}, 32'(bus.vec), 32'(exp_vec));
    tick();
    bus.inta_n = 1'b1;
    tick();
    eoi_o = bus.eoi;
    check({tag, "_vec_oe_off"}, 32'(bus.vec_oe), 32'd0);
    tick();
  endtask

  task automatic ack(input string tag, input logic [7:0] set, input logic [7:0] exp_vec,
                     output logic [7:0] eoi_o);
    bus.isr_set = set;
    pulse1();
    bus.isr_set = 8'h00;
    pulse2(tag, exp_vec, eoi_o);
  endtask

  task automatic ocw2(input logic [7:0] d, output logic [7:0] eoi_o);
    bus.ocw2_wr   = 1'b1;
    bus.ocw2_data = d;
    tick();
    bus.ocw2_wr   = 1'b0;
    eoi_o         = bus.eoi;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.inta_n    = 1'b1;
    bus.intr_in   = 1'b0;
    bus.isr_set   = 8'h00;
    bus.aeoi      = 1'b0;
    bus.icw2_wr   = 1'b0;
    bus.icw2_data = 5'h00;
    bus.ocw2_wr   = 1'b0;
    bus.ocw2_data = 8'h00;

    // Reset held while INTA toggles.
    for (int i = 0; i < 6; i++) begin
      bus.inta_n = ~bus.inta_n;
      tick();
    end
    bus.inta_n = 1'b1;
    check("rst_isr", 32'(bus.isr), 32'h00);
    check("rst_eoi", 32'(bus.eoi), 32'h00);
    check("rst_sp", 32'(bus.sp), 32'd7);
    check("rst_vec", 32'(bus.vec), 32'h00);
    check("rst_vec_oe", 32'(bus.vec_oe), 32'd0);
    check("rst_int_out", 32'(bus.int_out), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Full acknowledge of IR3.
    bus.icw2_wr   = 1'b1;
    bus.icw2_data = 5'h08;
    bus.intr_in   = 1'b1;
    tick();
    bus.icw2_wr = 1'b0;
    check("int_out_idle", 32'(bus.int_out), 32'd1);
    bus.isr_set = 8'h08;
    pulse1();
    bus.isr_set = 8'h00;
    bus.intr_in = 1'b0;
    check("ack_isr_set", 32'(bus.isr), 32'h08);
    check("ack_int_out_busy", 32'(bus.int_out), 32'd0);
    check("ack_vec_oe_between", 32'(bus.vec_oe), 32'd0);
    pulse2("ack", 8'h43, eoi_seen);
    check("ack_no_eoi", 32'(eoi_seen), 32'h00);
    check("ack_isr_kept", 32'(bus.isr), 32'h08);
    ocw2(8'h63, eoi_seen);
    check("seoi_pulse", 32'(eoi_seen), 32'h08);
    check("seoi_isr", 32'(bus.isr), 32'h00);
    tick();
    check("seoi_pulse_end", 32'(bus.eoi), 32'h00);

    // Spurious acknowledge with AEOI.
    bus.aeoi = 1'b1;
    ack("spur", 8'h00, 8'h47, eoi_seen);
    check("spur_no_eoi", 32'(eoi_seen), 32'h00);
    check("spur_isr", 32'(bus.isr), 32'h00);
    bus.aeoi = 1'b0;

    // Non-specific EOI at sp=7 then sp=6.
    ack("ir0", 8'h01, 8'h40, eoi_seen);
    ack("ir7", 8'h80, 8'h47, eoi_seen);
    check("nseoi_pre_isr", 32'(bus.isr), 32'h81);
    ocw2(8'h20, eoi_seen);
    check("nseoi_sp7_eoi", 32'(eoi_seen), 32'h01);
    check("nseoi_sp7_isr", 32'(bus.isr), 32'h80);
    tick();
    check("nseoi_pulse_end", 32'(bus.eoi), 32'h00);
    ocw2(8'hC6, eoi_seen);
    check("setpri_sp", 32'(bus.sp), 32'd6);
    ack("ir0b", 8'h01, 8'h40, eoi_seen);
    ocw2(8'h20, eoi_seen);
    check("nseoi_sp6_eoi", 32'(eoi_seen), 32'h80);
    check("nseoi_sp6_isr", 32'(bus.isr), 32'h01);
    ocw2(8'h60, eoi_seen);
    ocw2(8'h20, eoi_seen);
    check("nseoi_empty_eoi", 32'(eoi_seen), 32'h00);
    check("nseoi_empty_sp", 32'(bus.sp), 32'd6);
    ocw2(8'h62, eoi_seen);
    check("seoi_clear_bit_eoi", 32'(eoi_seen), 32'h00);

    // Rotate on specific EOI.
    ack("ir3", 8'h08, 8'h43, eoi_seen);
    ocw2(8'hE3, eoi_seen);
    check("rseoi_eoi", 32'(eoi_seen), 32'h08);
    check("rseoi_isr", 32'(bus.isr), 32'h00);
    check("rseoi_sp", 32'(bus.sp), 32'd3);

    // Set and specific EOI of bit 3 in one cycle: set wins, pulse still seen.
    ack("ir3b", 8'h08, 8'h43, eoi_seen);
    bus.isr_set   = 8'h08;
    bus.inta_n    = 1'b0;
    bus.ocw2_wr   = 1'b1;
    bus.ocw2_data = 8'h63;
    tick();
    bus.ocw2_wr = 1'b0;
    bus.isr_set = 8'h00;
    check("setclr_isr", 32'(bus.isr), 32'h08);
    check("setclr_eoi", 32'(bus.eoi), 32'h08);
    tick();
    bus.inta_n = 1'b1;
    tick();
    tick();
    pulse2("setclr", 8'h43, eoi_seen);
    ocw2(8'h63, eoi_seen);
    check("setclr_cleanup", 32'(bus.isr), 32'h00);

    // AEOI with rotate request.
    bus.aeoi = 1'b1;
    ocw2(8'h80, eoi_seen);
    bus.isr_set = 8'h20;
    pulse1();
    bus.isr_set = 8'h00;
    check("aeoi_isr_held", 32'(bus.isr), 32'h20);
    pulse2("aeoi", 8'h45, eoi_seen);
    check("aeoi_eoi", 32'(eoi_seen), 32'h20);
    check("aeoi_isr_clr", 32'(bus.isr), 32'h00);
`ifdef ROTATE_AEOI_EN
    check("aeoi_sp", 32'(bus.sp), 32'd5);
`else
    check("aeoi_sp", 32'(bus.sp), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
